// File: rtl/d_sram_like_bridge.sv
// Data-side bridge: turns each M-stage SRAM-style access into one sram-like
// transaction, stalls the core while it is in flight and holds read data until release.
module d_sram_like_bridge #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_sram_en,
    input  logic [3:0]        data_sram_wen,
    input  logic [ADDR_W-1:0] data_sram_addr,
    input  logic [31:0]       data_sram_wdata,
    output logic [31:0]       data_sram_rdata,
    output logic              d_stall,
    input  logic              longest_stall,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        DONE      = 2'd2
    } bridgeStateT;

    bridgeStateT state;
    logic [31:0] rdataBuf;
    logic [1:0]  lowBits;
    logic [1:0]  unusedAddrBits;

    // DONE waits for the whole pipeline to move so the same access is never re-issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            rdataBuf <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_sram_en && data_addr_ok) begin
                        state <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (data_data_ok) begin
                        rdataBuf <= data_rdata;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (!longest_stall) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The byte enable pattern picks the transfer size and the low address bits.
    always_comb begin
        data_size = 2'd2;
        lowBits   = 2'b00;
        case (data_sram_wen)
            4'b0011: begin data_size = 2'd1; lowBits = 2'b00; end
            4'b1100: begin data_size = 2'd1; lowBits = 2'b10; end
            4'b0001: begin data_size = 2'd0; lowBits = 2'b00; end
            4'b0010: begin data_size = 2'd0; lowBits = 2'b01; end
            4'b0100: begin data_size = 2'd0; lowBits = 2'b10; end
            4'b1000: begin data_size = 2'd0; lowBits = 2'b11; end
            default: begin data_size = 2'd2; lowBits = 2'b00; end
        endcase
    end

    assign unusedAddrBits  = data_sram_addr[1:0];
    assign data_addr       = {data_sram_addr[ADDR_W-1:2], lowBits};
    assign data_req        = (state == IDLE) && data_sram_en;
    assign d_stall         = data_req || (state == WAIT_DATA);
    assign data_wr         = |data_sram_wen;
    assign data_wdata      = data_sram_wdata;
    assign data_sram_rdata = rdataBuf;

endmodule
